// File: rtl/vga_timing_pkg.sv
// 640x480 VGA timing constants and the counter compare points derived from them.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int unsigned CntW = 10;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t H_LAST       = cnt_t'(H_TOTAL - 1);
  localparam cnt_t H_VIS_END    = cnt_t'(H_VISIBLE);
  localparam cnt_t H_SYNC_FIRST = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t H_SYNC_LAST  = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);

  localparam cnt_t V_LAST       = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_VIS_END    = cnt_t'(V_VISIBLE);
  localparam cnt_t V_SYNC_FIRST = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t V_SYNC_LAST  = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  // Inclusive window test used for the sync pulses.
  function automatic logic in_window(cnt_t cnt, cnt_t first, cnt_t last);
    return (cnt >= first) && (cnt <= last);
  endfunction

endpackage

// File: rtl/pix_en_div.sv
// Clock divider producing a one-cycle pixel enable every DIV system clocks.
module pix_en_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic pix_en_o
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  logic [DivW-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Decoded from the register only, so pix_en is low during and right after reset.
  assign pix_en_o = (div_q == DivLast);

endmodule

// File: rtl/vga_scan_gen.sv
// VGA 640x480 scan generator: pixel/line counters, sync/visible decode and line/frame ticks.
import vga_timing_pkg::*;

module vga_scan_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x_pos,
  output logic [8:0] y_pos,
  output logic       line_tick,
  output logic       frame_tick
);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;
  logic h_wrap, v_wrap;
  logic line_tick_q, frame_tick_q;

  pix_en_div #(
    .DIV (DIV)
  ) u_pix_en_div (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .pix_en_o (pix_en)
  );

  // Both wraps are resolved in one next-state so the counters never pass their last value.
  always_comb begin
    h_wrap  = pix_en && (h_cnt_q == H_LAST);
    v_wrap  = h_wrap && (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + cnt_t'(1);
    end
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      line_tick_q  <= h_wrap;
      frame_tick_q <= v_wrap;
    end
  end

  always_comb begin
    hsync    = !in_window(h_cnt_q, H_SYNC_FIRST, H_SYNC_LAST);
    vsync    = !in_window(v_cnt_q, V_SYNC_FIRST, V_SYNC_LAST);
    video_on = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
    x_pos    = (h_cnt_q < H_VIS_END) ? h_cnt_q : '0;
    y_pos    = (v_cnt_q < V_VIS_END) ? v_cnt_q[8:0] : '0;
  end

  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen: a cycle model feeds a queue that a negedge monitor drains.
module tb_vga_scan_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en, hsync, vsync, video_on, line_tick, frame_tick;
  logic [9:0] x_pos;
  logic [8:0] y_pos;

  always #5 clk = ~clk;

  vga_scan_gen #(
    .DIV (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .line_tick  (line_tick),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int pix_en;
    int hsync;
    int vsync;
    int video_on;
    int x;
    int y;
    int line_tick;
    int frame_tick;
  } exp_t;

  exp_t sb_q[$];

  // Model state: pixel index since reset and clock phase within the pixel.
  int n_pix = 0;
  int phase = 0;

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;

  int mon_cyc = 0;
  int lt_prev = -1;
  int vs_run = 0;
  int hs_run = 0;

  task automatic report(input string name, input int actual, input int required);
    errors++;
    if (fail_prints < 40) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
      fail_prints++;
    end
  endtask

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) report(name, actual, required);
  endtask

  function automatic int mh();
    return n_pix % 800;
  endfunction

  function automatic int mv();
    return (n_pix / 800) % 525;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int h, v;
    h = mh();
    v = mv();
    e.pix_en     = (phase == 3) ? 1 : 0;
    e.hsync      = (h >= 656 && h <= 751) ? 0 : 1;
    e.vsync      = (v >= 490 && v <= 491) ? 0 : 1;
    e.video_on   = (h < 640 && v < 480) ? 1 : 0;
    e.x          = (h < 640) ? h : 0;
    e.y          = (v < 480) ? v : 0;
    e.line_tick  = (phase == 0 && h == 0 && n_pix != 0) ? 1 : 0;
    e.frame_tick = (phase == 0 && (n_pix % 420000) == 0 && n_pix != 0) ? 1 : 0;
    return e;
  endfunction

  // Advance one clock; jump_v >= 0 moves the model to that row (matching a forced v_cnt).
  task automatic step(input int jump_v);
    logic rs;
    @(posedge clk);
    rs = rst_n;
    if (!rs) begin
      n_pix = 0;
      phase = 0;
    end else if (phase == 3) begin
      phase = 0;
      n_pix++;
    end else begin
      phase++;
    end
    if (jump_v >= 0) n_pix = jump_v * 800 + (n_pix % 800);
    #1;
    sb_q.push_back(model_out());
  endtask

  task automatic wait_pos(input int h, input int v, input int ph);
    int budget;
    budget = 20000;
    while (!(mh() == h && mv() == v && phase == ph)) begin
      if (budget == 0) begin
        checks++;
        report("wait_pos_timeout", mh(), h);
        return;
      end
      budget--;
      step(-1);
    end
  endtask

  // Skip ahead vertically; only called mid-line so no wrap coincides with the forced edge.
  task automatic jump_v(input int new_v);
    @(negedge clk);
    #1;
    force dut.v_cnt_q = 10'(new_v);
    step(new_v);
    release dut.v_cnt_q;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst_n) lt_prev = -1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("pix_en", int'(pix_en), e.pix_en);
        check("hsync", int'(hsync), e.hsync);
        check("vsync", int'(vsync), e.vsync);
        check("video_on", int'(video_on), e.video_on);
        check("x_pos", int'(x_pos), e.x);
        check("y_pos", int'(y_pos), e.y);
        check("line_tick", int'(line_tick), e.line_tick);
        check("frame_tick", int'(frame_tick), e.frame_tick);
        check("x_range", (int'(x_pos) < 640) ? 1 : 0, 1);
        check("y_range", (int'(y_pos) < 480) ? 1 : 0, 1);
        check("h_cnt_range", (int'(dut.h_cnt_q) < 800) ? 1 : 0, 1);
        check("v_cnt_range", (int'(dut.v_cnt_q) < 525) ? 1 : 0, 1);
        if (line_tick) begin
          if (lt_prev >= 0) check("line_period", mon_cyc - lt_prev, 3200);
          lt_prev = mon_cyc;
        end
        if (!hsync) hs_run++;
        else if (hs_run > 0) begin
          check("hsync_low_len", hs_run, 384);
          hs_run = 0;
        end
        if (!vsync) vs_run++;
        else if (vs_run > 0) begin
          check("vsync_low_len", vs_run, 6400);
          vs_run = 0;
        end
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0;
    repeat (3) step(-1);
    check("rst_pix_en", int'(pix_en), 0);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);
    check("rst_video_on", int'(video_on), 1);
    check("rst_x_pos", int'(x_pos), 0);
    check("rst_y_pos", int'(y_pos), 0);
    check("rst_line_tick", int'(line_tick), 0);
    check("rst_frame_tick", int'(frame_tick), 0);
    rst_n = 1'b1;

    // Release: pix_en at cycles 3, 7, 11; position held until the first pixel edge.
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step(-1);
      check("pix_en_start", int'(pix_en), (k % 4 == 3) ? 1 : 0);
      if (k <= 3) begin
        check("start_x_hold", int'(x_pos), 0);
        check("start_video_on", int'(video_on), 1);
      end
    end
    check("x_after_two_pix", int'(x_pos), 2);

    wait_pos(639, 0, 3);
    check("last_visible_on", int'(video_on), 1);
    check("last_visible_x", int'(x_pos), 639);
    step(-1);
    check("fp_video_off", int'(video_on), 0);
    check("fp_x_zero", int'(x_pos), 0);

    wait_pos(655, 0, 3);
    check("pre_hsync", int'(hsync), 1);
    step(-1);
    check("hsync_fall", int'(hsync), 0);
    wait_pos(751, 0, 3);
    check("hsync_last", int'(hsync), 0);
    step(-1);
    check("hsync_rise", int'(hsync), 1);

    wait_pos(799, 0, 3);
    check("pre_line_tick", int'(line_tick), 0);
    step(-1);
    check("line_tick_1", int'(line_tick), 1);
    check("line1_y", int'(y_pos), 1);
    check("line1_x", int'(x_pos), 0);
    check("line1_frame_tick", int'(frame_tick), 0);
    step(-1);
    check("line_tick_drop", int'(line_tick), 0);

    jump_v(478);
    wait_pos(639, 479, 2);
    check("last_pixel_on", int'(video_on), 1);
    check("last_pixel_x", int'(x_pos), 639);
    check("last_pixel_y", int'(y_pos), 479);
    wait_pos(0, 480, 0);
    check("vfp_video_off", int'(video_on), 0);
    check("vfp_y_zero", int'(y_pos), 0);
    check("vfp_line_tick", int'(line_tick), 1);
    check("vfp_vsync", int'(vsync), 1);

    jump_v(488);
    wait_pos(799, 489, 3);
    check("pre_vsync", int'(vsync), 1);
    step(-1);
    check("vsync_fall", int'(vsync), 0);
    wait_pos(799, 491, 3);
    check("vsync_last", int'(vsync), 0);
    step(-1);
    check("vsync_rise", int'(vsync), 1);

    jump_v(523);
    wait_pos(799, 524, 3);
    check("corner_pix_en", int'(pix_en), 1);
    check("corner_frame_tick", int'(frame_tick), 0);
    step(-1);
    check("wrap_line_tick", int'(line_tick), 1);
    check("wrap_frame_tick", int'(frame_tick), 1);
    check("wrap_video_on", int'(video_on), 1);
    check("wrap_x", int'(x_pos), 0);
    check("wrap_y", int'(y_pos), 0);
    step(-1);
    check("frame_tick_drop", int'(frame_tick), 0);

    // Mid-frame reset at (300,200).
    jump_v(200);
    wait_pos(300, 200, 1);
    rst_n = 1'b0;
    step(-1);
    check("mid_rst_h_cnt", int'(dut.h_cnt_q), 0);
    check("mid_rst_v_cnt", int'(dut.v_cnt_q), 0);
    check("mid_rst_hsync", int'(hsync), 1);
    check("mid_rst_vsync", int'(vsync), 1);
    check("mid_rst_pix_en", int'(pix_en), 0);
    check("mid_rst_x", int'(x_pos), 0);
    rst_n = 1'b1;
    step(-1);
    step(-1);
    check("restart_pix_en_c2", int'(pix_en), 0);
    step(-1);
    check("restart_pix_en_c3", int'(pix_en), 1);
    wait_pos(0, 1, 0);
    check("restart_line_tick", int'(line_tick), 1);
    check("restart_y", int'(y_pos), 1);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter DIV, default 4: system clocks per pixel; only 4 needs to be supported (100 MHz clk gives 25 MHz pixel rate).
REQ-002 clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 pix_en  output  1  pixel-rate enable: one clk cycle high out of every DIV cycles.
REQ-005 hsync  output  1  horizontal sync, active-low.
REQ-006 vsync  output  1  vertical sync, active-low.
REQ-007 video_on  output  1  high while the scan position is inside the 640x480 visible area.
REQ-008 x_pos  output  10  visible column 0..639; drives x_pos of the snake/food controllers.
REQ-009 y_pos  output  9  visible row 0..479; drives y_pos of the snake/food controllers.
REQ-010 line_tick  output  1  one-clk pulse at the start of every line.
REQ-011 frame_tick  output  1  one-clk pulse at the start of every frame.

Function
REQ-012 2-bit divider counts 0..3 and wraps; pix_en SHALL be 1 exactly in cycles where the divider equals 3.
REQ-013 h_cnt (10 bit) SHALL advance only in pix_en cycles: 0..799, then wrap to 0.
REQ-014 v_cnt (10 bit) SHALL advance only in pix_en cycles where h_cnt=799: 0..524, then wrap to 0.
REQ-015 Horizontal timing: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-016 Vertical timing: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-017 hsync SHALL be 0 iff 656<=h_cnt<=751.
REQ-018 vsync SHALL be 0 iff 490<=v_cnt<=491.
REQ-019 video_on SHALL be 1 iff h_cnt<640 and v_cnt<480.
REQ-020 x_pos SHALL equal h_cnt when h_cnt<640, else 0.
REQ-021 y_pos SHALL equal v_cnt[8:0] when v_cnt<480, else 0.
REQ-022 hsync, vsync, video_on, x_pos and y_pos SHALL be decoded only from registered counters.
REQ-023 Those outputs SHALL change only on the clk edge that ends a pix_en cycle.
REQ-024 Decode latency is 0 cycles from the counter registers; there SHALL be no combinational path from any input.
REQ-025 line_tick SHALL be registered and high for the single clk cycle after the edge on which h_cnt wraps 799->0.
REQ-026 frame_tick SHALL be registered and high for the single clk cycle after the edge on which (h_cnt,v_cnt) wraps (799,524)->(0,0).
REQ-027 frame_tick SHALL coincide with a line_tick.
REQ-028 Simultaneous h and v wrap SHALL be handled atomically: v_cnt never reads 525, and h_cnt never reads 800.
REQ-029 Timing: line period 3200 clk; frame period 1,680,000 clk.

Reset
REQ-030 While rst_n=0 at a clk edge: divider=0, h_cnt=0, v_cnt=0.
REQ-031 Reset output values: pix_en=0, line_tick=0, frame_tick=0, hsync=1, vsync=1, video_on=1, x_pos=0, y_pos=0.
REQ-032 Reset asserted mid-frame SHALL take effect on the next clk edge with no partial-line completion.
REQ-033 After reset release, the first pix_en SHALL occur in the 4th clk cycle.
REQ-034 No tick SHALL be emitted for the frame that starts at reset release.

Structure
REQ-035 Package vga_timing_pkg SHALL hold H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525.
REQ-036 Compare values SHALL be derived from these package constants, not hard-coded.
REQ-037 Sub-module pix_en_div SHALL hold the divider and generate pix_en.
REQ-038 Counters and decode SHALL be in vga_scan_gen.

Verification
REQ-039 Reset then release: pix_en high at clk cycles 3, 7, 11, ...; x_pos=0, y_pos=0, video_on=1 until the first pix_en edge.
REQ-040 Line timing: video_on falls after 640 pixels (2560 clk); hsync falls at h_cnt=656, rises at h_cnt=752 (low for 384 clk); line_tick period is 3200 clk.
REQ-041 Frame timing: vsync low exactly for lines 490-491 (6400 clk); frame_tick period is 1,680,000 clk; y_pos=0 while v_cnt>=480.
REQ-042 Wrap corner: at (799,524) the next pix_en edge gives (0,0); line_tick=1 and frame_tick=1 in the same cycle; counters never read 800 or 525.
REQ-043 Mid-frame reset at (300,200): next edge gives h_cnt=0, v_cnt=0, hsync=1, vsync=1, pix_en=0; normal sequence restarts.
REQ-044 Scoreboard check over two full frames: x_pos<640, y_pos<480, and video_on consistent with REQ-019 on every clk cycle.
